// File: rtl/sap1_control_sequencer.sv
`default_nettype none
// =============================================================================
// sap1_control_sequencer : SAP-1 hardwired ring-counter sequencer and decoder
// Rev 1.0 : initial release
// =============================================================================
module sap1_control_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       run,
  input  logic       step,
  input  logic       mem_rdy,
  output logic [5:0] T,
  output logic       CP,
  output logic       EP,
  output logic       LM,
  output logic       CE,
  output logic       LI,
  output logic       EI,
  output logic       LA,
  output logic       EA,
  output logic       SU,
  output logic       EU,
  output logic       LB,
  output logic       LO,
  output logic       LDA,
  output logic       ADD,
  output logic       SUB,
  output logic       OUT,
  output logic       HLT_I,
  output logic       NOP,
  output logic       HLT,
  output logic       busy,
  output logic       instr_done,
  output logic [7:0] icount
);

  typedef enum logic [2:0] {
    S_PAUSE  = 3'd0,
    S_T1     = 3'd1,
    S_T2     = 3'd2,
    S_T3     = 3'd3,
    S_T4     = 3'd4,
    S_T5     = 3'd5,
    S_T6     = 3'd6,
    S_HALTED = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic       hlt_q, hlt_d;
  logic [7:0] icount_q, icount_d;

  logic w_mem_op;
  logic w_mem_read;
  logic w_stall;

  assign LDA   = (opcode == 4'b0000);
  assign ADD   = (opcode == 4'b0001);
  assign SUB   = (opcode == 4'b0010);
  assign OUT   = (opcode == 4'b1110);
  assign HLT_I = (opcode == 4'b1111);
  assign NOP   = ~(LDA | ADD | SUB | OUT | HLT_I);

  // Only T3 and the operand fetch in T5 wait on RAM; every other state ignores mem_rdy.
  assign w_mem_op   = LDA | ADD | SUB;
  assign w_mem_read = (state_q == S_T3) || ((state_q == S_T5) && w_mem_op);
  assign w_stall    = w_mem_read && !mem_rdy;

  always_comb begin
    state_d  = state_q;
    hlt_d    = hlt_q;
    icount_d = icount_q;
    case (state_q)
      S_PAUSE:  if (run || step) state_d = S_T1;
      S_T1:     state_d = S_T2;
      S_T2:     state_d = S_T3;
      S_T3:     if (!w_stall) state_d = S_T4;
      S_T4: begin
        if (HLT_I) begin
          state_d = S_HALTED;
          hlt_d   = 1'b1;
        end else begin
          state_d = S_T5;
        end
      end
      S_T5:     if (!w_stall) state_d = S_T6;
      S_T6: begin
        state_d  = run ? S_T1 : S_PAUSE;
        icount_d = icount_q + 8'd1;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_PAUSE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_PAUSE;
      hlt_q    <= 1'b0;
      icount_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      hlt_q    <= hlt_d;
      icount_q <= icount_d;
    end
  end

  always_comb begin
    T  = 6'b000000;
    CP = 1'b0; EP = 1'b0; LM = 1'b0; CE = 1'b0;
    LI = 1'b0; EI = 1'b0; LA = 1'b0; EA = 1'b0;
    SU = 1'b0; EU = 1'b0; LB = 1'b0; LO = 1'b0;
    case (state_q)
      S_T1: begin
        T  = 6'b000001;
        EP = 1'b1;
        LM = 1'b1;
      end
      S_T2: begin
        T  = 6'b000010;
        CP = 1'b1;
      end
      S_T3: begin
        T  = 6'b000100;
        CE = 1'b1;
        LI = mem_rdy;
      end
      S_T4: begin
        T = 6'b001000;
        if (w_mem_op) begin
          EI = 1'b1;
          LM = 1'b1;
        end else if (OUT) begin
          EA = 1'b1;
          LO = 1'b1;
        end
      end
      S_T5: begin
        T = 6'b010000;
        // Load strobes fire only in the cycle RAM data is valid, so a stall loads once.
        if (w_mem_op) CE = 1'b1;
        if (LDA) LA = mem_rdy;
        if (ADD || SUB) LB = mem_rdy;
      end
      S_T6: begin
        T = 6'b100000;
        if (ADD || SUB) begin
          LA = 1'b1;
          EU = 1'b1;
          SU = SUB;
        end
      end
      default: T = 6'b000000;
    endcase
  end

  assign HLT        = hlt_q;
  assign busy       = |T;
  assign instr_done = (state_q == S_T6);
  assign icount     = icount_q;

endmodule
`default_nettype wire
